dds_phase_ctrl: RTL and testbench
=================================

DDS_PHASE_CTRL -- requirements
Module: dds_phase_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  PHASE_W, 32, phase accumulator width
  ADDR_WIDTH, 10, waveform RAM address width (ADDR_WIDTH <= PHASE_W)
  DATA_WIDTH, 32, waveform sample width
  DIV_W, 16, tick divider width
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  en  in  1  run request; 1 = IDLE->RUN, 0 = RUN->IDLE
  cfg_valid  in  1  config offer
  cfg_ready  out  1  config accept
  cfg_ftw  in  PHASE_W  frequency tuning word
  cfg_pow  in  PHASE_W  phase offset word
  cfg_div  in  DIV_W  tick divider; one tick per cfg_div+1 cycles
  ram_busy  in  1  waveform RAM write in progress; RAM read data frozen
  ram_addr  out  ADDR_WIDTH  RAM read address, registered
  rd_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_addr
  sample  out  DATA_WIDTH  output sample, registered
  sample_valid  out  1  one-cycle strobe per sample
  wrap  out  1  one-cycle strobe on accumulator overflow

Function
REQ-003 States SHALL be IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; in IDLE, accumulator, divider and ram_addr hold.
REQ-004 Config handshake: a transfer occurs when cfg_valid & cfg_ready at a rising edge; cfg_ready SHALL be 1 in IDLE and in RUN with no pending config, 0 while a config is pending.
REQ-005 In IDLE, an accepted config SHALL load ftw/pow/div on that edge and clear accumulator and divider.
REQ-006 In RUN, an accepted config SHALL be held pending and applied on the edge where wrap is generated; accumulator is not cleared; the divider reloads.
REQ-007 Tick: in RUN with ram_busy=0, the divider counts 0..div then restarts; tick=1 when count==div; while ram_busy=1 the divider SHALL hold and no tick occurs.
REQ-008 On a tick edge: acc <= (acc+ftw) mod 2^PHASE_W; ram_addr <= bits [PHASE_W-1 : PHASE_W-ADDR_WIDTH] of (acc+ftw+pow) mod 2^PHASE_W; a read issue flag is pipelined.
REQ-009 wrap SHALL pulse 1 cycle on the tick edge where acc+ftw carries out of PHASE_W bits.
REQ-010 Latency: tick at cycle N -> ram_addr at N+1 -> RAM data at N+2 -> sample<=rd_data and sample_valid=1 at N+3; sustained rate is one sample per tick (every cycle when div=0).
REQ-011 An issued read whose RAM read cycle (N+1->N+2) coincides with ram_busy=1 SHALL be discarded: no sample_valid, and sample holds.
REQ-012 Samples already in flight when en falls SHALL still be delivered.
REQ-013 sample SHALL hold its last value between strobes.

Reset
REQ-014 Asynchronous rst_n low SHALL force state IDLE, acc=0, ftw=pow=div=0, divider=0, pending cleared, ram_addr=0, sample=0, sample_valid=0, wrap=0, cfg_ready=1; in-flight reads are dropped.
REQ-015 After rst_n rises, the first tick SHALL occur no earlier than the edge after en=1 is sampled.

Verification
REQ-016 Reset mid-RUN with reads in flight -> all outputs 0 next cycle, cfg_ready=1, no sample_valid after release until a new tick.
REQ-017 IDLE cfg ftw=2^22, pow=0, div=0, then en=1, RAM preloaded mem[i]=i -> ram_addr 1,2,3,...; first sample_valid 3 cycles after first tick; samples 1,2,3,... every cycle.
REQ-018 div=3, ftw=2^22 -> sample_valid every 4th cycle, ram_addr advances by 1 per strobe.
REQ-019 ftw=2^31, pow=2^30 -> ram_addr 768,256,768,...; wrap on every 2nd tick.
REQ-020 In RUN ftw=2^22, offer ftw=2^23 -> cfg_ready drops; address step stays 1 until the wrap at ram_addr 0; step is 2 after it; cfg_ready returns to 1.
REQ-021 ram_busy=1 for 5 cycles mid-stream -> no ticks, the in-flight read during busy is dropped, and the address sequence resumes without skipping.

Source files
------------

// File: rtl/dds_phase_ctrl.sv
// DDS phase controller: tick divider, phase accumulator with deferred config update,
// and a RAM read pipeline that turns accumulator phase into registered output samples.
module dds_phase_ctrl #(
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PHASE_W-1:0]    cfg_ftw,
    input  logic [PHASE_W-1:0]    cfg_pow,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  ram_busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid,
    output logic                  wrap
);

    localparam int unsigned ADDR_SHIFT = PHASE_W - ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] ftw;
        logic [PHASE_W-1:0] pow;
        logic [DIV_W-1:0]   div;
    } cfg_t;

    state_t                state;
    state_t                next_state;
    cfg_t                  cur_cfg;
    cfg_t                  pend_cfg;
    cfg_t                  cfg_in_c;
    logic                  pend;
    logic                  pend_next_c;
    logic [PHASE_W-1:0]    acc;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick_c;
    logic                  accept_c;
    logic                  carry_c;
    logic [PHASE_W:0]      acc_sum_c;
    logic [PHASE_W-1:0]    phase_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic                  issue_q;
    logic                  read_ok_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, tick, handshake and phase arithmetic
    always_comb begin
        next_state  = state;
        tick_c      = 1'b0;
        accept_c    = cfg_valid & cfg_ready;
        cfg_in_c    = '{ftw: cfg_ftw, pow: cfg_pow, div: cfg_div};
        acc_sum_c   = {1'b0, acc} + {1'b0, cur_cfg.ftw};
        carry_c     = acc_sum_c[PHASE_W];
        phase_c     = acc_sum_c[PHASE_W-1:0] + cur_cfg.pow;
        addr_c      = ADDR_WIDTH'(phase_c >> ADDR_SHIFT);
        pend_next_c = pend;
        unique case (state)
            IDLE: begin
                if (en) begin
                    next_state = RUN;
                end
                pend_next_c = 1'b0;
            end
            RUN: begin
                if (!en) begin
                    next_state = IDLE;
                end
                tick_c = !ram_busy && (div_cnt == cur_cfg.div);
                if (tick_c && carry_c) begin
                    pend_next_c = 1'b0;
                end
                if (accept_c) begin
                    pend_next_c = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Config, accumulator, divider and address generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_cfg   <= '0;
            pend_cfg  <= '0;
            pend      <= 1'b0;
            acc       <= '0;
            div_cnt   <= '0;
            ram_addr  <= '0;
            wrap      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            wrap      <= 1'b0;
            pend      <= pend_next_c;
            cfg_ready <= (next_state == IDLE) || !pend_next_c;
            if (state == IDLE) begin
                // A config left pending when RUN ended is applied here unless a newer one arrives
                if (accept_c) begin
                    cur_cfg <= cfg_in_c;
                    acc     <= '0;
                    div_cnt <= '0;
                end else if (pend) begin
                    cur_cfg <= pend_cfg;
                    acc     <= '0;
                    div_cnt <= '0;
                end
            end else begin
                if (tick_c) begin
                    acc      <= acc_sum_c[PHASE_W-1:0];
                    ram_addr <= addr_c;
                    div_cnt  <= '0;
                    wrap     <= carry_c;
                    if (carry_c && pend) begin
                        cur_cfg <= pend_cfg;
                    end
                end else if (!ram_busy) begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (accept_c) begin
                    pend_cfg <= cfg_in_c;
                end
            end
        end
    end

    // Read pipeline: issue -> RAM read cycle (dropped if busy) -> sample capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q      <= 1'b0;
            read_ok_q    <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            issue_q      <= tick_c;
            read_ok_q    <= issue_q && !ram_busy;
            sample_valid <= read_ok_q;
            if (read_ok_q) begin
                sample <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Bench for dds_phase_ctrl: directed runs with a queue of expected samples checked
// by an independent monitor, plus direct checks of reset and handshake state.
`timescale 1ns/1ps
module tb_dds_phase_ctrl;

    localparam int unsigned PHASE_W    = 32;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DIV_W      = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [PHASE_W-1:0]    cfg_ftw = '0;
    logic [PHASE_W-1:0]    cfg_pow = '0;
    logic [DIV_W-1:0]      cfg_div = '0;
    logic                  ram_busy = 1'b0;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] rd_data = '0;
    logic [DATA_WIDTH-1:0] sample;
    logic                  sample_valid;
    logic                  wrap;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic                  wrp;
        int                    gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mark = 0;
    int   c = 0;
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    dds_phase_ctrl #(
        .PHASE_W(PHASE_W), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ftw(cfg_ftw), .cfg_pow(cfg_pow), .cfg_div(cfg_div),
        .ram_busy(ram_busy), .ram_addr(ram_addr), .rd_data(rd_data),
        .sample(sample), .sample_valid(sample_valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM whose read data freezes while a write is in progress
    always @(posedge clk) begin
        if (!ram_busy) rd_data <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: wrap is associated with the sample it produced two cycles later
    initial begin : monitor
        logic w1, w2;
        exp_t e;
        w1 = 1'b0;
        w2 = 1'b0;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got data=%0d at cycle %0d, required no sample", sample, cyc);
                end else begin
                    e = q.pop_front();
                    if (sample !== e.data || w2 !== e.wrp || (e.gap != 0 && (cyc - mark) != e.gap)) begin
                        errors++;
                        $display("FAIL sample: got data=%0d wrap=%0b gap=%0d, required data=%0d wrap=%0b gap=%0d",
                                 sample, w2, cyc - mark, e.data, e.wrp, e.gap);
                    end
                end
                mark = cyc;
            end
            w2 = w1;
            w1 = wrap;
        end
    end

    task automatic push(input logic [DATA_WIDTH-1:0] d, input logic w, input int g);
        exp_t e;
        e.data = d;
        e.wrp  = w;
        e.gap  = g;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic cfg_send(input logic [PHASE_W-1:0] f, input logic [PHASE_W-1:0] p,
                            input logic [DIV_W-1:0] d);
        int n;
        n = 0;
        cfg_ftw   = f;
        cfg_pow   = p;
        cfg_div   = d;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cfg_ready) begin
            errors++;
            $display("FAIL cfg_accept: cfg_ready=0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        step(2);
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    task automatic start_run();
        en   = 1'b1;
        c    = cyc;
        mark = cyc;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = DATA_WIDTH'(i);
        step(3);
        chk("rst_sample", 64'(sample), 64'd0);
        chk("rst_sample_valid", 64'(sample_valid), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1'b1;
        step(2);

        // Unit step, one sample per cycle, in-flight samples survive en falling
        cfg_send(32'h0040_0000, 32'h0, 16'd0);
        for (int k = 1; k <= 8; k++) push(DATA_WIDTH'(k), 1'b0, (k == 1) ? 4 : 1);
        start_run();
        wait_until(c + 8);
        en = 1'b0;
        drain();
        chk("idle_sample_hold", 64'(sample), 64'd8);
        chk("idle_ram_addr_hold", 64'(ram_addr), 64'd8);
        chk("idle_no_valid", 64'(sample_valid), 64'd0);

        // Divider of 3: one sample every fourth cycle
        cfg_send(32'h0040_0000, 32'h0, 16'd3);
        for (int k = 1; k <= 4; k++) push(DATA_WIDTH'(k), 1'b0, (k == 1) ? 7 : 4);
        start_run();
        wait_until(c + 16);
        en = 1'b0;
        drain();

        // Half-cycle step with quarter offset: addresses alternate, wrap every second tick
        cfg_send(32'h8000_0000, 32'h4000_0000, 16'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k % 2 == 1) push(DATA_WIDTH'(768), 1'b0, (k == 1) ? 4 : 1);
            else            push(DATA_WIDTH'(256), 1'b1, 1);
        end
        start_run();
        wait_until(c + 6);
        en = 1'b0;
        drain();

        // Config offered while running takes effect only at the next wrap
        cfg_send(32'h0040_0000, 32'h0, 16'd0);
        for (int k = 1; k <= 1030; k++) begin
            if (k <= 1024) push(DATA_WIDTH'(k % 1024), (k == 1024), (k == 1) ? 4 : 1);
            else           push(DATA_WIDTH'(2 * (k - 1024)), 1'b0, 1);
        end
        start_run();
        wait_until(c + 10);
        cfg_send(32'h0080_0000, 32'h0, 16'd0);
        chk("cfg_ready_pending", 64'(cfg_ready), 64'd0);
        wait_until(c + 1024);
        chk("cfg_ready_before_wrap", 64'(cfg_ready), 64'd0);
        wait_until(c + 1025);
        chk("cfg_ready_after_wrap", 64'(cfg_ready), 64'd1);
        wait_until(c + 1030);
        en = 1'b0;
        drain();

        // RAM busy for five cycles: ticks stall, the read issued into busy is lost
        cfg_send(32'h0040_0000, 32'h0, 16'd0);
        push(DATA_WIDTH'(1), 1'b0, 4);
        push(DATA_WIDTH'(2), 1'b0, 1);
        push(DATA_WIDTH'(3), 1'b0, 1);
        push(DATA_WIDTH'(5), 1'b0, 7);
        for (int k = 6; k <= 9; k++) push(DATA_WIDTH'(k), 1'b0, 1);
        start_run();
        wait_until(c + 5);
        ram_busy = 1'b1;
        wait_until(c + 10);
        ram_busy = 1'b0;
        wait_until(c + 14);
        en = 1'b0;
        drain();

        // Reset mid-run with reads in flight
        cfg_send(32'h0040_0000, 32'h0, 16'd0);
        push(DATA_WIDTH'(1), 1'b0, 4);
        push(DATA_WIDTH'(2), 1'b0, 1);
        push(DATA_WIDTH'(3), 1'b0, 1);
        start_run();
        wait_until(c + 6);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        step(1);
        chk("mid_rst_sample", 64'(sample), 64'd0);
        chk("mid_rst_sample_valid", 64'(sample_valid), 64'd0);
        chk("mid_rst_wrap", 64'(wrap), 64'd0);
        chk("mid_rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        step(1);
        rst_n = 1'b1;
        step(10);
        chk("post_rst_queue", 64'(q.size()), 64'd0);

        // After reset the config is zero: first sample still needs a full tick-to-sample latency
        for (int k = 1; k <= 3; k++) push(DATA_WIDTH'(0), 1'b0, (k == 1) ? 4 : 1);
        start_run();
        wait_until(c + 3);
        en = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
